fwd_track_unit: RTL and testbench

FWD_TRACK_UNIT -- requirements
Module: fwd_track_unit

---
 rtl/fwd_track_unit.sv | 113 +++++++++++
 tb/tb_fwd_track_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_track_unit.sv
// ----------------------------------------------------------------------------
// fwd_track_unit
//   Tracks destination registers of the DEPTH instructions downstream of ID
//   (entry 0 = EX ... entry DEPTH-1 = WB). It produces per-port forwarding
//   selects and a load-use stall, both combinationally in the same cycle.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   id_valid            : ID holds a real instruction
//   id_rw/id_regwr      : ID destination register / writes a register
//   id_memtoreg         : ID instruction is a load
//   id_ra/id_ruse       : per-port source addresses and read enables
//   flush               : squash the ID instruction (beats stall)
//   cnt_clr             : synchronous clear of stall_cnt
//   fwd_sel             : per port, 0 = register file, k = entry k-1
//   stall               : hold PC/ID and insert a bubble
//   stall_cnt           : saturating count of stall cycles
// ----------------------------------------------------------------------------
module fwd_track_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned NPORT    = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    localparam int unsigned SELW    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [REG_AW-1:0]         id_rw,
    input  logic                      id_regwr,
    input  logic                      id_memtoreg,
    input  logic [NPORT*REG_AW-1:0]   id_ra,
    input  logic [NPORT-1:0]          id_ruse,
    input  logic                      flush,
    input  logic                      cnt_clr,
    output logic [NPORT*SELW-1:0]     fwd_sel,
    output logic                      stall,
    output logic [15:0]               stall_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [DEPTH-1:0]                 r_v;
    logic [DEPTH-1:0]                 r_regwr;
    logic [DEPTH-1:0]                 r_ld;
    logic [DEPTH-1:0][REG_AW-1:0]     r_rw;
    logic [15:0]                      r_cnt;

    logic [NPORT-1:0][SELW-1:0]       w_sel;
    logic [NPORT-1:0]                 w_ldu;
    logic [REG_AW-1:0]                w_ra;
    logic                             w_stall;
    logic                             w_issue;

    // Entry shift: entry 0 takes ID (or a bubble), older entries age by one.
    assign w_issue = id_valid & ~w_stall & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v     <= '0;
            r_regwr <= '0;
            r_ld    <= '0;
            r_rw    <= '0;
        end else begin
            r_v[0]     <= w_issue;
            r_regwr[0] <= id_regwr;
            r_ld[0]    <= id_memtoreg;
            r_rw[0]    <= id_rw;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_v[i]     <= r_v[i-1];
                r_regwr[i] <= r_regwr[i-1];
                r_ld[i]    <= r_ld[i-1];
                r_rw[i]    <= r_rw[i-1];
            end
        end
    end

    // Per-port match search; scanning oldest to youngest lets the youngest
    // match overwrite, and only that match decides whether a load blocks.
    always_comb begin
        w_sel = '0;
        w_ldu = '0;
        w_ra  = '0;
        for (int p = 0; p < int'(NPORT); p++) begin
            w_ra = id_ra[p*REG_AW +: REG_AW];
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (r_v[i] && r_regwr[i] && (r_rw[i] == w_ra) &&
                    (w_ra != '0) && id_ruse[p]) begin
                    w_sel[p] = SELW'(i + 1);
                    w_ldu[p] = r_ld[i] && (i < int'(LOAD_LAT));
                end
            end
        end
    end

    assign w_stall = id_valid & ~flush & (|w_ldu);
    assign stall   = w_stall;
    assign fwd_sel = w_stall ? '0 : w_sel;

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_fwd_track_unit.sv
// ----------------------------------------------------------------------------
// tb_fwd_track_unit
//   Directed and random checks of fwd_track_unit against a queue-based
//   reference model. A second instance (DEPTH = LOAD_LAT = 31) stalls on 31 of
//   every 32 cycles, which makes counter saturation reachable quickly.
// ----------------------------------------------------------------------------
module tb_fwd_track_unit;

    typedef struct {
        bit       v;
        bit [4:0] rw;
        bit       regwr;
        bit       ld;
    } ent_t;

    localparam int M_DEPTH = 3;
    localparam int S_DEPTH = 31;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        id_valid, id_regwr, id_memtoreg, flush, cnt_clr;
    logic [4:0]  id_rw;
    logic [9:0]  id_ra;
    logic [1:0]  id_ruse;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [15:0] stall_cnt;

    logic        s_valid, s_regwr, s_ld, s_flush, s_clr;
    logic [4:0]  s_rw;
    logic [9:0]  s_ra;
    logic [1:0]  s_ruse;
    logic [9:0]  s_fwd_sel;
    logic        s_stall;
    logic [15:0] s_stall_cnt;

    int tests = 0;
    int fails = 0;

    ent_t m_q[$];
    ent_t s_q[$];
    int   m_cnt;
    int   s_cnt;
    int   o_s0, o_s1, o_st;

    always #5 clk = ~clk;

    fwd_track_unit u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rw(id_rw),
        .id_regwr(id_regwr), .id_memtoreg(id_memtoreg), .id_ra(id_ra),
        .id_ruse(id_ruse), .flush(flush), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_sel), .stall(stall), .stall_cnt(stall_cnt)
    );

    fwd_track_unit #(.DEPTH(S_DEPTH), .LOAD_LAT(S_DEPTH)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(s_valid), .id_rw(s_rw),
        .id_regwr(s_regwr), .id_memtoreg(s_ld), .id_ra(s_ra),
        .id_ruse(s_ruse), .flush(s_flush), .cnt_clr(s_clr),
        .fwd_sel(s_fwd_sel), .stall(s_stall), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: youngest valid writer of a nonzero source; a load there that
    // is still younger than ll blocks an issuing ID instruction.
    function automatic void model_eval(input ent_t q[$], input int ll,
                                       input bit valid, input bit fl,
                                       input bit [4:0] a0, input bit [4:0] a1,
                                       input bit [1:0] use_p,
                                       output int st, output int s0, output int s1);
        int  sel[2];
        bit  blk;
        bit [4:0] a[2];
        a[0] = a0;
        a[1] = a1;
        blk  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            sel[p] = 0;
            if (use_p[p] && a[p] != 5'd0) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].v && q[i].regwr && q[i].rw == a[p]) begin
                        sel[p] = i + 1;
                        if (q[i].ld && i < ll) blk = 1'b1;
                        break;
                    end
                end
            end
        end
        st = (valid && !fl && blk) ? 1 : 0;
        s0 = st ? 0 : sel[0];
        s1 = st ? 0 : sel[1];
    endfunction

    // One ID cycle on the main instance: drive, check, then age the model.
    task automatic step(input bit v, input bit [4:0] rw, input bit wr, input bit ld,
                        input bit [4:0] a0, input bit [4:0] a1, input bit [1:0] use_p,
                        input bit fl, input bit clr);
        int st, s0, s1;
        @(negedge clk);
        id_valid = v; id_rw = rw; id_regwr = wr; id_memtoreg = ld;
        id_ra = {a1, a0}; id_ruse = use_p; flush = fl; cnt_clr = clr;
        #1;
        model_eval(m_q, 1, v, fl, a0, a1, use_p, st, s0, s1);
        chk("stall", 32'(stall), 32'(st));
        chk("fwd_sel0", 32'(fwd_sel[1:0]), 32'(s0));
        chk("fwd_sel1", 32'(fwd_sel[3:2]), 32'(s1));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        o_st = int'(stall); o_s0 = int'(fwd_sel[1:0]); o_s1 = int'(fwd_sel[3:2]);
        @(posedge clk);
        m_q.push_front('{v && st == 0 && !fl, rw, wr, ld});
        void'(m_q.pop_back());
        if (clr) m_cnt = 0;
        else if (st != 0 && m_cnt != 65535) m_cnt++;
    endtask

    task automatic bubble();
        step(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        int st, s0, s1, n;
        bit done;
        rst_n = 1'b0;
        id_valid = 0; id_rw = '0; id_regwr = 0; id_memtoreg = 0;
        id_ra = '0; id_ruse = '0; flush = 0; cnt_clr = 0;
        s_valid = 0; s_rw = '0; s_regwr = 0; s_ld = 0;
        s_ra = '0; s_ruse = '0; s_flush = 0; s_clr = 0;
        m_cnt = 0; s_cnt = 0;
        for (int i = 0; i < M_DEPTH; i++) m_q.push_back('{1'b0, 5'd0, 1'b0, 1'b0});
        for (int i = 0; i < S_DEPTH; i++) s_q.push_back('{1'b0, 5'd0, 1'b0, 1'b0});

        // Reset state: drive a would-be reader while held in reset.
        #2;
        id_valid = 1; id_ra = {5'd7, 5'd5}; id_ruse = 2'b11;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        id_valid = 0; id_ruse = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // WB forward: add r5, two bubbles, read r5 on port 0.
        step(1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        bubble(); bubble();
        step(1, 5'd9, 1, 0, 5'd5, 5'd0, 2'b01, 0, 0);
        chk("wb_fwd_sel0", 32'(o_s0), 32'd3);
        chk("wb_fwd_stall", 32'(o_st), 32'd0);

        // Youngest wins.
        step(1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        step(1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00, 0, 0);
        step(1, 5'd9, 1, 0, 5'd5, 5'd0, 2'b01, 0, 0);
        chk("young_sel0", 32'(o_s0), 32'd1);

        // Load-use on port 1: one stall cycle, then forward from entry 1.
        bubble(); bubble(); bubble();
        step(1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0);
        step(1, 5'd8, 1, 0, 5'd0, 5'd7, 2'b10, 0, 0);
        chk("lu_stall", 32'(o_st), 32'd1);
        chk("lu_sel1_zero", 32'(o_s1), 32'd0);
        step(1, 5'd8, 1, 0, 5'd0, 5'd7, 2'b10, 0, 0);
        chk("lu_stall_clear", 32'(o_st), 32'd0);
        chk("lu_sel1", 32'(o_s1), 32'd2);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // $0 never matches.
        step(1, 5'd0, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0);
        step(1, 5'd8, 1, 0, 5'd0, 5'd0, 2'b11, 0, 0);
        chk("r0_stall", 32'(o_st), 32'd0);
        chk("r0_sel", 32'(o_s0), 32'd0);

        // Flush beats stall and inserts a bubble.
        step(1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0);
        step(1, 5'd8, 1, 0, 5'd7, 5'd0, 2'b01, 1, 0);
        chk("flush_stall", 32'(o_st), 32'd0);
        step(1, 5'd8, 1, 0, 5'd7, 5'd0, 2'b01, 0, 0);
        chk("flush_bubble_sel0", 32'(o_s0), 32'd2);

        // Reset in the middle of a load-use stall.
        step(1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00, 0, 0);
        @(negedge clk);
        id_valid = 1; id_rw = 5'd8; id_regwr = 1; id_memtoreg = 0;
        id_ra = {5'd0, 5'd7}; id_ruse = 2'b01; flush = 0; cnt_clr = 0;
        #1;
        model_eval(m_q, 1, 1, 0, 5'd7, 5'd0, 2'b01, st, s0, s1);
        chk("pre_rst_stall", 32'(stall), 32'(st));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_sel", 32'(fwd_sel), 32'd0);
        chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
        foreach (m_q[i]) m_q[i].v = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 5'd8, 1, 0, 5'd7, 5'd7, 2'b11, 0, 0);
        chk("post_rst_sel0", 32'(o_s0), 32'd0);

        // Random traffic over a small register set to provoke hazards.
        for (int k = 0; k < 400; k++) begin
            step(($urandom % 8) != 0, 5'($urandom % 4), ($urandom % 4) != 0,
                 ($urandom % 3) == 0, 5'($urandom % 4), 5'($urandom % 4),
                 2'($urandom % 4), ($urandom % 10) == 0, ($urandom % 40) == 0);
        end

        // Saturation on the long instance: a load that reads its own target.
        id_valid = 0; id_ruse = '0; flush = 0; cnt_clr = 0;
        n = 0;
        done = 1'b0;
        while (!done && n < 80000) begin
            @(negedge clk);
            s_valid = 1; s_rw = 5'd7; s_regwr = 1; s_ld = 1;
            s_ra = {5'd7, 5'd7}; s_ruse = 2'b01; s_flush = 0; s_clr = 0;
            #1;
            model_eval(s_q, S_DEPTH, 1, 0, 5'd7, 5'd7, 2'b01, st, s0, s1);
            if (n % 1024 == 0) chk("sat_stall", 32'(s_stall), 32'(st));
            if (s_cnt == 65535 && st != 0) begin
                chk("sat_cnt_max", 32'(s_stall_cnt), 32'hFFFF);
                chk("sat_stall_at_clr", 32'(s_stall), 32'd1);
                s_clr = 1;
                done = 1'b1;
            end
            @(posedge clk);
            s_q.push_front('{st == 0, 5'd7, 1'b1, 1'b1});
            void'(s_q.pop_back());
            if (s_clr) s_cnt = 0;
            else if (st != 0 && s_cnt != 65535) s_cnt++;
            n++;
        end
        if (!done) chk("sat_timeout", 32'd1, 32'd0);
        @(negedge clk);
        s_clr = 0; s_valid = 0;
        #1;
        chk("sat_cnt_clr", 32'(s_stall_cnt), 32'(s_cnt));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
